// File: rtl/iobus_arbiter_if.sv
// iobus_arbiter_if: requester handshakes plus the shared iobus master port
interface iobus_arbiter_if;
  logic        m0_req, m0_we, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_owner;
  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
    output m0_ready, m0_rdata, m1_ready, m1_rdata, bus_addr, bus_wdata, bus_we, bus_owner
  );
  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata, bus_addr, bus_wdata, bus_we, bus_owner
  );
endinterface

// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin sharing of the iobus between CPU (m0) and loader (m1) with region wait states
module iobus_arbiter #(
  parameter int          MEM_WAIT = 0,
  parameter int          DV_WAIT  = 2,
  parameter int          CNT_W    = 4,
  parameter logic [19:0] DV_HI    = 20'hFFFFF
) (
  input logic clk,
  input logic rst_n,
  iobus_arbiter_if.master io
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic owner, last_served, lwe, grant, gnt_owner, fin;
  logic [31:0] laddr, lwdata, sel_addr;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    gnt_owner = (io.m0_req && io.m1_req) ? ~last_served : io.m1_req;
    sel_addr = gnt_owner ? io.m1_addr : io.m0_addr;
    grant = 1'b0;
    fin = 1'b0;
    state_nx = state;
    io.bus_addr = '0;
    io.bus_wdata = '0;
    io.bus_we = 1'b0;
    io.m0_ready = 1'b0;
    io.m1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        grant = io.m0_req | io.m1_req;
        state_nx = grant ? ACCESS : IDLE;
      end
      ACCESS: begin
        io.bus_addr = laddr;
        io.bus_wdata = lwdata;
        fin = (cnt == '0);
        io.bus_we = fin & lwe;
        state_nx = fin ? DONE : ACCESS;
      end
      DONE: begin
        io.m0_ready = ~owner;
        io.m1_ready = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign io.bus_owner = owner;
  // last_served starts at 1 so the first tie goes to the CPU
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= 1'b0;
      last_served <= 1'b1;
      lwe <= 1'b0;
      laddr <= '0;
      lwdata <= '0;
      cnt <= '0;
      io.m0_rdata <= '0;
      io.m1_rdata <= '0;
    end else begin
      if (grant) begin
        owner <= gnt_owner;
        lwe <= gnt_owner ? io.m1_we : io.m0_we;
        laddr <= sel_addr;
        lwdata <= gnt_owner ? io.m1_wdata : io.m0_wdata;
        cnt <= (sel_addr[31:12] == DV_HI) ? CNT_W'(DV_WAIT) : CNT_W'(MEM_WAIT);
      end else if (state == ACCESS && !fin) cnt <= cnt - 1'b1;
      if (fin) begin
        last_served <= owner;
        if (!lwe && !owner) io.m0_rdata <= io.bus_rdata;
        if (!lwe && owner) io.m1_rdata <= io.bus_rdata;
      end
    end
endmodule

// File: tb/tb_iobus_arbiter.sv
// tb_iobus_arbiter: directed and random checks against a transaction-schedule model of the arbiter
module tb_iobus_arbiter;
  localparam int MEM_WAIT = 0, DV_WAIT = 2;
  logic clk = 1'b0, rst_n = 1'b0, seed = 1'b1;
  int checks = 0, failures = 0, cyc = 0, nwe = 0;
  always #5 clk = ~clk;
  iobus_arbiter_if bus();
  iobus_arbiter #(.MEM_WAIT(MEM_WAIT), .DV_WAIT(DV_WAIT)) dut (.clk(clk), .rst_n(rst_n), .io(bus.master));
  // device behind the iobus: 16 words, combinational read, strobed write
  logic [31:0] dev [16];
  always @(posedge clk)
    if (seed) for (int i = 0; i < 16; i++) dev[i] <= (i == 4) ? 32'hDEADBEEF : i * 32'h11111111;
    else if (bus.bus_we) dev[bus.bus_addr[5:2]] <= bus.bus_wdata;
  assign bus.bus_rdata = dev[bus.bus_addr[5:2]];
  // model: one transaction in flight, timed by its age since the grant edge
  logic [31:0] mm [16];
  logic [31:0] mrd [2];
  logic [31:0] maddr, mwd;
  bit act, own, last, mwe;
  int age, w;
  function automatic int waits(input logic [31:0] a);
    return (a[31:12] == 20'hFFFFF) ? DV_WAIT : MEM_WAIT;
  endfunction
  task automatic model_reset();
    act = 0; own = 0; last = 1; mrd[0] = 0; mrd[1] = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    bit in_acc;
    in_acc = act && age <= w;
    chk("bus_addr", bus.bus_addr, in_acc ? maddr : 32'h0);
    chk("bus_wdata", bus.bus_wdata, in_acc ? mwd : 32'h0);
    chk("bus_we", 32'(bus.bus_we), 32'(act && age == w && mwe));
    chk("m0_ready", 32'(bus.m0_ready), 32'(act && age == w + 1 && !own));
    chk("m1_ready", 32'(bus.m1_ready), 32'(act && age == w + 1 && own));
    chk("m0_rdata", bus.m0_rdata, mrd[0]);
    chk("m1_rdata", bus.m1_rdata, mrd[1]);
    chk("bus_owner", 32'(bus.bus_owner), 32'(own));
  endtask
  task automatic step();
    bit r0, r1, we0, we1;
    logic [31:0] a0, a1, d0, d1;
    r0 = bus.m0_req; r1 = bus.m1_req; we0 = bus.m0_we; we1 = bus.m1_we;
    a0 = bus.m0_addr; a1 = bus.m1_addr; d0 = bus.m0_wdata; d1 = bus.m1_wdata;
    @(posedge clk); #1;
    cyc++;
    if (bus.bus_we) nwe++;
    if (!rst_n) model_reset();
    else if (act) begin
      if (age == w) begin
        if (mwe) mm[maddr[5:2]] = mwd;
        else mrd[own] = mm[maddr[5:2]];
      end
      age++;
      if (age == w + 2) act = 0;
    end else if (r0 || r1) begin
      own = (r0 && r1) ? ~last : r1;
      last = own; act = 1; age = 0;
      mwe = own ? we1 : we0; maddr = own ? a1 : a0; mwd = own ? d1 : d0;
      w = waits(maddr);
    end
    check_all();
  endtask
  task automatic set_req(input bit k, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (k) begin bus.m1_req = 1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; end
    else begin bus.m0_req = 1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; end
  endtask
  task automatic wait_ready(input bit k, input bit drop);
    int n = 0;
    do begin step(); n++; end while (!(k ? bus.m1_ready : bus.m0_ready) && n < 20);
    chk("ready_seen", 32'(k ? bus.m1_ready : bus.m0_ready), 32'd1);
    if (drop) begin if (k) bus.m1_req = 0; else bus.m0_req = 0; end
  endtask
  initial begin
    int n, prev, we_before;
    bit order [4];
    bit rq [2];
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    for (int i = 0; i < 16; i++) mm[i] = (i == 4) ? 32'hDEADBEEF : i * 32'h11111111;
    model_reset();
    @(posedge clk); #1;
    seed = 0;
    check_all();
    rst_n = 1;
    // tie held: strict alternation, m0 first after reset
    set_req(0, 0, 32'h40, 0);
    set_req(1, 0, 32'h44, 0);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin step(); n++; end while (!(bus.m0_ready || bus.m1_ready) && n < 20);
      chk("t3_ready_seen", 32'(bus.m0_ready | bus.m1_ready), 32'd1);
      order[i] = bus.m1_ready;
    end
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(order[i]), 32'(i % 2));
    bus.m0_req = 0; bus.m1_req = 0;
    step(); step();
    // memory read
    set_req(0, 0, 32'h0000_0010, 0);
    wait_ready(0, 1);
    chk("t1_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rdata", bus.m1_rdata, mrd[1]);
    step();
    // device write: one strobe
    we_before = nwe;
    set_req(0, 1, 32'hFFFF_F000, 32'h5A);
    wait_ready(0, 1);
    step();
    chk("t2_we_count", nwe - we_before, 1);
    chk("t2_dev", dev[0], 32'h5A);
    // loader write, req dropped and address moved after grant
    we_before = nwe;
    set_req(1, 1, 32'h20, 32'hCAFE0001);
    step();
    bus.m1_req = 0; bus.m1_addr = 32'h30; bus.m1_wdata = 32'h0BAD0BAD;
    wait_ready(1, 1);
    step();
    chk("t4_we_count", nwe - we_before, 1);
    chk("t4_dev_target", dev[8], 32'hCAFE0001);
    chk("t4_dev_other", dev[12], 32'hCCCCCCCC);
    // async reset in the middle of a device write
    we_before = nwe;
    set_req(0, 1, 32'hFFFF_F004, 32'h77);
    step(); step();
    #2 rst_n = 0;
    #1 model_reset();
    bus.m0_req = 0;
    check_all();
    step(); step();
    rst_n = 1;
    step();
    chk("t5_we_count", nwe - we_before, 0);
    chk("t5_dev", dev[1], 32'h11111111);
    set_req(0, 0, 32'h8, 0);
    set_req(1, 0, 32'hC, 0);
    n = 0;
    do begin step(); n++; end while (!(bus.m0_ready || bus.m1_ready) && n < 20);
    chk("t5_first_tie_m0", 32'(bus.m0_ready), 32'd1);
    bus.m0_req = 0;
    wait_ready(1, 1);
    step();
    // back-to-back held reads
    prev = 0;
    set_req(0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      wait_ready(0, 0);
      if (i > 0) chk("t6_spacing", cyc - prev, 3);
      prev = cyc;
      bus.m0_addr = 32'(i + 1) << 2;
    end
    bus.m0_req = 0;
    step();
    // random traffic
    rq[0] = 0; rq[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++)
        if (!rq[k] && $urandom_range(3) == 0) begin
          rq[k] = 1;
          set_req(k[0], 1'($urandom), {($urandom_range(1) == 1) ? 20'hFFFFF : 20'($urandom), 6'd0, 4'($urandom), 2'd0}, $urandom);
        end
      step();
      for (int k = 0; k < 2; k++)
        if (k == 1 ? bus.m1_ready : bus.m0_ready) begin
          rq[k] = 0;
          if (k == 1) bus.m1_req = 0; else bus.m0_req = 0;
        end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
